// File: rtl/lb_app_regbank.sv
// Application register bank on the local bus: ID, scratch and config registers,
// a free-running cycle counter and GPS PPS timestamping behind a fixed-latency read pipeline.
module lb_app_regbank #(
    parameter int          READ_PIPE = 2,    // legal range 1..4
    parameter logic [23:0] BASE_ADDR = 24'h010000,
    parameter logic [31:0] ID_WORD   = 32'h4d415242
) (
    input  logic        lb_clk,
    input  logic        lb_rstn,
    input  logic [23:0] lb_addr,
    input  logic        lb_strobe,
    input  logic        lb_rd,
    input  logic        lb_write,
    input  logic [31:0] lb_data_out,
    output logic [31:0] lb_data_in,
    input  logic        gps_pps,
    output logic [3:0]  ext_config
);
    localparam logic [3:0] OFF_ID        = 4'd0;
    localparam logic [3:0] OFF_SCRATCH   = 4'd1;
    localparam logic [3:0] OFF_EXTCFG    = 4'd2;
    localparam logic [3:0] OFF_CYCLES    = 4'd3;
    localparam logic [3:0] OFF_PPS_STAMP = 4'd4;
    localparam logic [3:0] OFF_PPS_COUNT = 4'd5;
    localparam logic [3:0] OFF_CTRL      = 4'd6;
    localparam logic [3:0] OFF_STATUS    = 4'd7;

    logic        hit;
    logic [3:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic        clr_count;
    logic        clr_seen;
    logic        pps_pulse;
    logic [31:0] rd_mux;

    logic [31:0] scratch_reg;
    logic [3:0]  ext_cfg_reg;
    logic [31:0] cycles_reg;
    logic [31:0] pps_stamp_reg;
    logic [31:0] pps_count_reg;
    logic        pps_seen_reg;
    logic        pps_sync1_reg;
    logic        pps_sync2_reg;
    logic        pps_sync3_reg;

    assign hit       = (lb_addr[23:4] == BASE_ADDR[23:4]);
    assign offset    = lb_addr[3:0];
    assign wr_en     = lb_strobe & lb_write & hit;
    assign rd_en     = lb_strobe & lb_rd & ~lb_write & hit;
    assign clr_count = wr_en && (offset == OFF_CTRL) && lb_data_out[0];
    assign clr_seen  = wr_en && (offset == OFF_CTRL) && lb_data_out[1];
    assign pps_pulse = pps_sync2_reg & ~pps_sync3_reg;
    assign ext_config = ext_cfg_reg;

    always_ff @(posedge lb_clk) begin
        if (!lb_rstn) begin
            scratch_reg <= '0;
            ext_cfg_reg <= '0;
            cycles_reg  <= '0;
        end else begin
            cycles_reg <= cycles_reg + 32'd1;
            if (wr_en && offset == OFF_SCRATCH)
                scratch_reg <= lb_data_out;
            if (wr_en && offset == OFF_EXTCFG)
                ext_cfg_reg <= lb_data_out[3:0];
        end
    end

    // sync1/sync2 resynchronise the async PPS input; sync3 is the edge-detect history.
    always_ff @(posedge lb_clk) begin
        if (!lb_rstn) begin
            pps_sync1_reg <= 1'b0;
            pps_sync2_reg <= 1'b0;
            pps_sync3_reg <= 1'b0;
            pps_stamp_reg <= '0;
            pps_count_reg <= '0;
            pps_seen_reg  <= 1'b0;
        end else begin
            pps_sync1_reg <= gps_pps;
            pps_sync2_reg <= pps_sync1_reg;
            pps_sync3_reg <= pps_sync2_reg;
            if (pps_pulse)
                pps_stamp_reg <= cycles_reg;
            // A clear in the same cycle as an edge takes priority over it.
            if (clr_count)
                pps_count_reg <= '0;
            else if (pps_pulse)
                pps_count_reg <= pps_count_reg + 32'd1;
            if (clr_seen)
                pps_seen_reg <= 1'b0;
            else if (pps_pulse)
                pps_seen_reg <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_ID:        rd_mux = ID_WORD;
            OFF_SCRATCH:   rd_mux = scratch_reg;
            OFF_EXTCFG:    rd_mux = {28'd0, ext_cfg_reg};
            OFF_CYCLES:    rd_mux = cycles_reg;
            OFF_PPS_STAMP: rd_mux = pps_stamp_reg;
            OFF_PPS_COUNT: rd_mux = pps_count_reg;
            OFF_CTRL:      rd_mux = '0;
            OFF_STATUS:    rd_mux = {31'd0, pps_seen_reg};
            default:       rd_mux = '0;
        endcase
    end

    // Stage 0 captures the mux only on a read hit so idle slots flow through as zero.
    genvar gi;
    generate
        for (gi = 0; gi < READ_PIPE; gi++) begin : g_stage
            logic [31:0] stage_reg;
            logic [31:0] stage_next;
            if (gi == 0) begin : g_first
                assign stage_next = rd_en ? rd_mux : 32'd0;
            end else begin : g_rest
                assign stage_next = g_stage[gi-1].stage_reg;
            end
            always_ff @(posedge lb_clk) begin
                if (!lb_rstn)
                    stage_reg <= '0;
                else
                    stage_reg <= stage_next;
            end
        end
    endgenerate

    assign lb_data_in = g_stage[READ_PIPE-1].stage_reg;

endmodule

// File: tb/tb_lb_app_regbank.sv
// Directed bench for lb_app_regbank: three instances (READ_PIPE 1, 2, 4) share one bus,
// output history is logged per cycle and compared against hand-computed values.
module tb_lb_app_regbank;
    localparam logic [23:0] BASE = 24'h010000;
    localparam logic [31:0] ID   = 32'h4d415242;

    logic        clk = 1'b0;
    logic        lb_rstn = 1'b0;
    logic [23:0] lb_addr = '0;
    logic        lb_strobe = 1'b0;
    logic        lb_rd = 1'b0;
    logic        lb_write = 1'b0;
    logic [31:0] lb_data_out = '0;
    logic        gps_pps = 1'b0;
    logic [31:0] dout1, dout2, dout4;
    logic [3:0]  cfg1, cfg2, cfg4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_cyc = 0;
    logic [31:0] hist1 [0:511];
    logic [31:0] hist2 [0:511];
    logic [31:0] hist4 [0:511];

    always #5 clk = ~clk;

    lb_app_regbank #(.READ_PIPE(1)) u_rp1 (
        .lb_clk(clk), .lb_rstn(lb_rstn), .lb_addr(lb_addr), .lb_strobe(lb_strobe),
        .lb_rd(lb_rd), .lb_write(lb_write), .lb_data_out(lb_data_out),
        .lb_data_in(dout1), .gps_pps(gps_pps), .ext_config(cfg1));
    lb_app_regbank #(.READ_PIPE(2)) u_rp2 (
        .lb_clk(clk), .lb_rstn(lb_rstn), .lb_addr(lb_addr), .lb_strobe(lb_strobe),
        .lb_rd(lb_rd), .lb_write(lb_write), .lb_data_out(lb_data_out),
        .lb_data_in(dout2), .gps_pps(gps_pps), .ext_config(cfg2));
    lb_app_regbank #(.READ_PIPE(4)) u_rp4 (
        .lb_clk(clk), .lb_rstn(lb_rstn), .lb_addr(lb_addr), .lb_strobe(lb_strobe),
        .lb_rd(lb_rd), .lb_write(lb_write), .lb_data_out(lb_data_out),
        .lb_data_in(dout4), .gps_pps(gps_pps), .ext_config(cfg4));

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle; outputs are logged on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        hist1[cyc] = dout1;
        hist2[cyc] = dout2;
        hist4[cyc] = dout4;
    endtask

    task automatic idle();
        lb_strobe = 1'b0;
        lb_rd = 1'b0;
        lb_write = 1'b0;
        lb_addr = '0;
        lb_data_out = '0;
    endtask

    task automatic drive_read(input logic [23:0] a);
        lb_addr = a;
        lb_strobe = 1'b1;
        lb_rd = 1'b1;
        lb_write = 1'b0;
        $display("cycle %0d: read  addr=%h", cyc + 1, a);
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
        lb_addr = a;
        lb_strobe = 1'b1;
        lb_rd = 1'b0;
        lb_write = 1'b1;
        lb_data_out = d;
        $display("cycle %0d: write addr=%h data=%h", cyc + 1, a, d);
        step();
        idle();
    endtask

    // Single read, checked on the READ_PIPE=2 instance two cycles after the strobe.
    task automatic read_check(input string tag, input logic [23:0] a, input logic [31:0] exp);
        int s;
        drive_read(a);
        step();
        s = cyc;
        idle();
        step();
        check_value(tag, hist2[s+1], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] baddr [4];
        logic [31:0] bexp [4];
        int s0, c, ref_stamp;
        baddr = '{BASE + 24'd0, BASE + 24'd1, BASE + 24'd2, BASE + 24'd0};
        bexp  = '{ID, 32'hdeadbeef, 32'h0000000f, ID};

        // Reset
        repeat (3) step();
        check_value("reset_dout", dout2, 32'd0);
        check_value("reset_cfg", {28'd0, cfg2}, 32'd0);
        lb_rstn = 1'b1;
        rst_cyc = cyc;

        // Basic reads
        read_check("rd_id", BASE + 24'd0, ID);
        read_check("rd_cycles", BASE + 24'd3, cyc - rst_cyc);
        read_check("rd_off8", BASE + 24'd8, 32'd0);
        step();
        check_value("idle_zero", dout2, 32'd0);
        read_check("rd_miss", BASE + 24'h10, 32'd0);

        // Writes
        bus_write(BASE + 24'd1, 32'hdeadbeef);
        bus_write(BASE + 24'd2, 32'hffffffff);
        check_value("extcfg_pin", {28'd0, cfg2}, 32'h0000000f);
        read_check("rd_scratch", BASE + 24'd1, 32'hdeadbeef);
        read_check("rd_extcfg", BASE + 24'd2, 32'h0000000f);
        bus_write(BASE + 24'h11, 32'h12345678);
        bus_write(BASE + 24'h12, 32'h00000000);
        check_value("miss_cfg", {28'd0, cfg2}, 32'h0000000f);
        read_check("miss_scratch", BASE + 24'd1, 32'hdeadbeef);
        bus_write(BASE + 24'd0, 32'h00000000);
        read_check("ro_id", BASE + 24'd0, ID);
        read_check("rd_ctrl", BASE + 24'd6, 32'd0);

        // Back-to-back reads, all three latencies
        step();
        for (int k = 0; k < 4; k++) begin
            drive_read(baddr[k]);
            step();
            if (k == 0) s0 = cyc;
        end
        idle();
        repeat (5) step();
        for (int k = 0; k < 4; k++) begin
            check_value($sformatf("b2b_rp1_%0d", k), hist1[s0+k], bexp[k]);
            check_value($sformatf("b2b_rp2_%0d", k), hist2[s0+k+1], bexp[k]);
            check_value($sformatf("b2b_rp4_%0d", k), hist4[s0+k+3], bexp[k]);
        end
        check_value("b2b_rp1_pre", hist1[s0-1], 32'd0);
        check_value("b2b_rp4_pre", hist4[s0+2], 32'd0);
        check_value("b2b_rp1_post", hist1[s0+4], 32'd0);
        check_value("b2b_rp2_post", hist2[s0+5], 32'd0);
        check_value("b2b_rp4_post", hist4[s0+7], 32'd0);

        // First PPS pulse
        c = cyc;
        #2 gps_pps = 1'b1;
        repeat (10) step();
        gps_pps = 1'b0;
        repeat (4) step();
        ref_stamp = c + 2 - rst_cyc;
        read_check("pps_count1", BASE + 24'd5, 32'd1);
        read_check("pps_status1", BASE + 24'd7, 32'd1);
        read_check("pps_stamp1", BASE + 24'd4, ref_stamp);

        // Second PPS pulse
        c = cyc;
        #3 gps_pps = 1'b1;
        repeat (10) step();
        gps_pps = 1'b0;
        repeat (4) step();
        ref_stamp = c + 2 - rst_cyc;
        read_check("pps_count2", BASE + 24'd5, 32'd2);
        read_check("pps_stamp2", BASE + 24'd4, ref_stamp);

        // CTRL clear coinciding with the detect pulse
        c = cyc;
        gps_pps = 1'b1;
        step();
        step();
        bus_write(BASE + 24'd6, 32'd3);
        repeat (8) step();
        gps_pps = 1'b0;
        repeat (4) step();
        ref_stamp = c + 2 - rst_cyc;
        read_check("clr_count", BASE + 24'd5, 32'd0);
        read_check("clr_status", BASE + 24'd7, 32'd0);
        read_check("clr_stamp", BASE + 24'd4, ref_stamp);

        // Counter wrap
        force u_rp2.cycles_reg = 32'hfffffffe;
        #1;
        release u_rp2.cycles_reg;
        drive_read(BASE + 24'd3);
        step();
        s0 = cyc;
        drive_read(BASE + 24'd3);
        step();
        drive_read(BASE + 24'd3);
        step();
        idle();
        repeat (2) step();
        check_value("wrap_0", hist2[s0+1], 32'hfffffffe);
        check_value("wrap_1", hist2[s0+2], 32'hffffffff);
        check_value("wrap_2", hist2[s0+3], 32'h00000000);

        // Reset while a read is in flight
        drive_read(BASE + 24'd1);
        step();
        s0 = cyc;
        idle();
        lb_rstn = 1'b0;
        step();
        check_value("rst_mid_rp2", dout2, 32'd0);
        lb_rstn = 1'b1;
        rst_cyc = cyc;
        repeat (4) step();
        check_value("rst_drop_rp2", hist2[s0+2], 32'd0);
        check_value("rst_drop_rp4", hist4[s0+3], 32'd0);
        check_value("rst_cfg", {28'd0, cfg2}, 32'd0);
        read_check("rst_scratch", BASE + 24'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
